// File: rtl/quad_encoder_array.sv
// -----------------------------------------------------------------------------
// quad_encoder_array
//   N-channel x4 quadrature encoder front end. Each channel synchronises its
//   asynchronous A/B inputs, decodes Gray-code transitions into +1/-1 steps,
//   keeps a wrapping signed position, flags illegal (double-bit) transitions,
//   and contributes to a windowed, saturating velocity measurement latched for
//   all channels together.
//
// Ports
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   ena        block enable (position, velocity window and error freeze when low)
//   enc_a      encoder A inputs, one per channel, asynchronous
//   enc_b      encoder B inputs, one per channel, asynchronous
//   clr        per-channel synchronous clear of position and error flag
//   pos_o      positions, channel i at [i*POS_W +: POS_W]
//   vel_o      velocities, channel i at [i*VEL_W +: VEL_W]
//   vel_valid  one-cycle pulse when vel_o has been updated
//   err_o      sticky illegal-transition flag per channel
//
// Configuration
//   ENC_FILTER_EN  when defined, each synchronised bit passes through a glitch
//                  filter that accepts a new level only after FILT_LEN
//                  consecutive equal samples. Undefined: no filter logic.
// -----------------------------------------------------------------------------
module quad_encoder_array #(
    parameter int N_CH       = 2,
    parameter int POS_W      = 16,
    parameter int VEL_W      = 12,
    parameter int SAMPLE_CYC = 50000,
    parameter int FILT_LEN   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    input  logic [N_CH-1:0]       enc_a,
    input  logic [N_CH-1:0]       enc_b,
    input  logic [N_CH-1:0]       clr,
    output logic [N_CH*POS_W-1:0] pos_o,
    output logic [N_CH*VEL_W-1:0] vel_o,
    output logic                  vel_valid,
    output logic [N_CH-1:0]       err_o
);

    localparam int TMR_W = $clog2(SAMPLE_CYC);
    // One window can move at most SAMPLE_CYC counts either way, so this signed
    // width can never wrap inside a window.
    localparam int ACC_W = $clog2(SAMPLE_CYC + 1) + 1;
    localparam int SUM_W = ((ACC_W > VEL_W) ? ACC_W : VEL_W) + 1;
    localparam logic signed [SUM_W-1:0] VEL_MAX = SUM_W'((2 ** (VEL_W - 1)) - 1);
    localparam logic signed [SUM_W-1:0] VEL_MIN = SUM_W'(-(2 ** (VEL_W - 1)));

    // Position of a {A,B} state along the forward sequence 00->01->11->10.
    function automatic logic [1:0] gray_pos(input logic [1:0] s);
        case (s)
            2'b00:   return 2'd0;
            2'b01:   return 2'd1;
            2'b11:   return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

    logic [N_CH-1:0] a_meta, a_sync, b_meta, b_sync;
    logic [TMR_W-1:0] timer;
    logic             window_end;

    // Synchronisers keep running regardless of ena.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_meta <= '0;
            a_sync <= '0;
            b_meta <= '0;
            b_sync <= '0;
        end else begin
            a_meta <= enc_a;
            a_sync <= a_meta;
            b_meta <= enc_b;
            b_sync <= b_meta;
        end
    end

    assign window_end = ena && (timer == TMR_W'(SAMPLE_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer     <= '0;
            vel_valid <= 1'b0;
        end else begin
            vel_valid <= window_end;
            if (ena) begin
                timer <= window_end ? '0 : timer + 1'b1;
            end
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [1:0]              raw_state, cur_state, prev_state, delta;
        logic                    primed, illegal, err;
        logic signed [1:0]       step;
        logic [POS_W-1:0]        pos;
        logic signed [ACC_W-1:0] acc;
        logic signed [SUM_W-1:0] closing_sum;
        logic [VEL_W-1:0]        vel, vel_next;

        assign raw_state = {a_sync[i], b_sync[i]};

`ifdef ENC_FILTER_EN
        localparam int FCNT_W = $clog2(FILT_LEN) + 1;
        logic [1:0]        filt_state, filt_take;
        logic [FCNT_W-1:0] filt_cnt [2];

        // A differing bit is taken on the cycle it is seen for the FILT_LEN-th
        // time in a row; the bypass lets the decoder use it on that same edge.
        always_comb begin
            filt_take = '0;
            for (int j = 0; j < 2; j++) begin
                filt_take[j] = (raw_state[j] != filt_state[j]) &&
                               (filt_cnt[j] == FCNT_W'(FILT_LEN - 1));
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                filt_state <= '0;
                for (int j = 0; j < 2; j++) begin
                    filt_cnt[j] <= '0;
                end
            end else begin
                for (int j = 0; j < 2; j++) begin
                    if (raw_state[j] == filt_state[j]) begin
                        filt_cnt[j] <= '0;
                    end else if (filt_take[j]) begin
                        filt_state[j] <= raw_state[j];
                        filt_cnt[j]   <= '0;
                    end else begin
                        filt_cnt[j] <= filt_cnt[j] + 1'b1;
                    end
                end
            end
        end

        assign cur_state = (filt_take & raw_state) | (~filt_take & filt_state);
`else
        assign cur_state = raw_state;
`endif

        always_comb begin
            delta   = gray_pos(cur_state) - gray_pos(prev_state);
            step    = 2'sb00;
            illegal = 1'b0;
            if (primed) begin
                case (delta)
                    2'd1:    step    = 2'sb01;
                    2'd3:    step    = 2'sb11;
                    2'd2:    illegal = 1'b1;
                    default: step    = 2'sb00;
                endcase
            end
        end

        // prev follows the input even while disabled so re-enabling cannot
        // produce a step from stale history.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                prev_state <= '0;
                primed     <= 1'b0;
            end else begin
                prev_state <= cur_state;
                primed     <= 1'b1;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                pos <= '0;
                err <= 1'b0;
            end else if (clr[i]) begin
                pos <= '0;
                err <= 1'b0;
            end else if (ena) begin
                pos <= pos + {{(POS_W - 2){step[1]}}, step};
                if (illegal) begin
                    err <= 1'b1;
                end
            end
        end

        // The terminal-cycle step belongs to the closing window.
        assign closing_sum = {{(SUM_W - ACC_W){acc[ACC_W-1]}}, acc} +
                             {{(SUM_W - 2){step[1]}}, step};

        always_comb begin
            if (closing_sum > VEL_MAX) begin
                vel_next = VEL_MAX[VEL_W-1:0];
            end else if (closing_sum < VEL_MIN) begin
                vel_next = VEL_MIN[VEL_W-1:0];
            end else begin
                vel_next = closing_sum[VEL_W-1:0];
            end
        end

        // Velocity keeps counting steps that clr discards from position.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                acc <= '0;
                vel <= '0;
            end else if (ena) begin
                if (window_end) begin
                    acc <= '0;
                    vel <= vel_next;
                end else begin
                    acc <= acc + {{(ACC_W - 2){step[1]}}, step};
                end
            end
        end

        assign pos_o[i*POS_W +: POS_W] = pos;
        assign vel_o[i*VEL_W +: VEL_W] = vel;
        assign err_o[i]                = err;
    end

endmodule
